// File: rtl/accel_pkg.sv
// Shared encodings for the CNN accelerator layer sequencer: phase codes,
// per-phase unit-enable vectors and small decode helpers.
package accel_pkg;

   localparam int unsigned DIM_W_DEF = 8;
   localparam int unsigned STATE_W   = 4;
   localparam int unsigned CODE_W    = 3;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE    = 4'd0,
      S_INIT    = 4'd1,
      S_DEPTH   = 4'd2,
      S_POINT   = 4'd3,
      S_POOL    = 4'd4,
      S_FLATTEN = 4'd5,
      S_FC1     = 4'd6,
      S_FC2     = 4'd7,
      S_ERROR   = 4'd15
   } state_e;

   // ERROR shares the external code of FC2; timeout_err tells them apart.
   localparam logic [CODE_W-1:0] ERROR_CODE = 3'd7;

   typedef struct packed {
      logic dsu;
      logic init_buffer;
      logic depth;
      logic point;
      logic flatten;
      logic fc1;
      logic fc2;
   } en_t;

   localparam en_t EN_OFF     = 7'b000_0000;
   localparam en_t EN_INIT    = 7'b111_1000;
   localparam en_t EN_DEPTH   = 7'b101_1000;
   localparam en_t EN_POINT   = 7'b100_1000;
   localparam en_t EN_POOL    = 7'b100_0000;
   localparam en_t EN_FLATTEN = 7'b000_0100;
   localparam en_t EN_FC1     = 7'b000_0010;
   localparam en_t EN_FC2     = 7'b000_0001;

   function automatic en_t en_of(input state_e s);
      case (s)
         S_INIT:    return EN_INIT;
         S_DEPTH:   return EN_DEPTH;
         S_POINT:   return EN_POINT;
         S_POOL:    return EN_POOL;
         S_FLATTEN: return EN_FLATTEN;
         S_FC1:     return EN_FC1;
         S_FC2:     return EN_FC2;
         default:   return EN_OFF;
      endcase
   endfunction

   function automatic logic [CODE_W-1:0] state_code(input state_e s);
      return (s == S_ERROR) ? ERROR_CODE : s[CODE_W-1:0];
   endfunction

   function automatic logic is_busy(input state_e s);
      return (s != S_IDLE) && (s != S_ERROR);
   endfunction

   function automatic logic is_conv(input state_e s);
      return (s == S_INIT) || (s == S_DEPTH) || (s == S_POINT) || (s == S_POOL);
   endfunction

endpackage

// File: rtl/phase_timer.sv
// Per-phase watchdog: counts cycles spent in the current phase and flags the
// last permitted cycle. LIMIT of 0 removes the counter entirely.
module phase_timer #(
   parameter int unsigned LIMIT = 65535
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expire_c
);

   generate
      if (LIMIT == 0) begin : g_off
         logic unused_c;
         assign unused_c = ^{clk, rst_n, clear, enable};
         assign expire_c = 1'b0;
      end else begin : g_on
         localparam int unsigned CNT_W = $clog2(LIMIT + 1);
         logic [CNT_W-1:0] cnt_q;

         // Counter value equals the number of completed cycles in this phase.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               cnt_q <= '0;
            end else if (clear || !enable) begin
               cnt_q <= '0;
            end else if (!expire_c) begin
               cnt_q <= cnt_q + CNT_W'(1);
            end
         end

         assign expire_c = enable && (cnt_q == CNT_W'(LIMIT - 1));
      end
   endgenerate

endmodule

// File: rtl/layer_sequencer.sv
// Layer-sequencing FSM for the depthwise-separable CNN accelerator: walks the
// conv stages, flatten and FC layers, driving unit enables and geometry.
module layer_sequencer
   import accel_pkg::*;
#(
   parameter int unsigned NUM_CONV       = 3,
   parameter int unsigned DIM_W          = DIM_W_DEF,
   parameter int unsigned FRAME_W        = 4,
   parameter int unsigned TIMEOUT_CYCLES = 65535,
   localparam int unsigned IDX_W         = (NUM_CONV > 1) ? $clog2(NUM_CONV) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               continuous,
   input  logic               abort,
   input  logic               cfg_we,
   input  logic [IDX_W-1:0]   cfg_idx,
   input  logic [DIM_W-1:0]   cfg_in_size,
   input  logic [DIM_W-1:0]   cfg_in_ch,
   input  logic [DIM_W-1:0]   cfg_out_ch,
   input  logic               init_buffer_done,
   input  logic               depth_done,
   input  logic               point_done,
   input  logic               pool_done,
   input  logic               flatten_done,
   input  logic               fc1_done,
   input  logic               fc2_done,
   output logic [2:0]         state,
   output logic [IDX_W-1:0]   conv_idx,
   output logic               DSU_en,
   output logic               init_buffer,
   output logic               depth_en,
   output logic               point_en,
   output logic               flatten_en,
   output logic               fc1,
   output logic               fc2,
   output logic [DIM_W-1:0]   input_size,
   output logic [DIM_W-1:0]   output_size,
   output logic [DIM_W-1:0]   input_channel,
   output logic [DIM_W-1:0]   output_channel,
   output logic               busy,
   output logic               frame_done,
   output logic               timeout_err,
   output logic [FRAME_W-1:0] feature_count
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CONV - 1);

   state_e               state_q, state_d;
   logic [IDX_W-1:0]     conv_q, conv_d;
   logic [FRAME_W-1:0]   count_q, count_d;
   logic                 frame_done_d;
   logic                 phase_done_c;
   logic                 expire_c;
   logic                 timer_clear_c;
   logic                 timer_en_c;
   logic                 cfg_ok_c;

   logic [DIM_W-1:0]     d_in_size_q [NUM_CONV];
   logic [DIM_W-1:0]     d_in_ch_q   [NUM_CONV];
   logic [DIM_W-1:0]     d_out_ch_q  [NUM_CONV];

   en_t                  en_q, en_d;
   logic [CODE_W-1:0]    code_q, code_d;
   logic                 busy_q, busy_d;
   logic                 timeout_q, timeout_d;
   logic                 frame_done_q;
   logic [DIM_W-1:0]     size_q, size_d;
   logic [DIM_W-1:0]     in_ch_q, in_ch_d;
   logic [DIM_W-1:0]     out_ch_q, out_ch_d;

   // Descriptor table is only writable while the datapath is quiescent.
   assign cfg_ok_c = cfg_we && !is_busy(state_q) && (32'(cfg_idx) < NUM_CONV);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NUM_CONV; i++) begin
            d_in_size_q[i] <= '0;
            d_in_ch_q[i]   <= '0;
            d_out_ch_q[i]  <= '0;
         end
      end else if (cfg_ok_c) begin
         d_in_size_q[cfg_idx] <= cfg_in_size;
         d_in_ch_q[cfg_idx]   <= cfg_in_ch;
         d_out_ch_q[cfg_idx]  <= cfg_out_ch;
      end
   end

   assign timer_clear_c = (state_d != state_q);
   assign timer_en_c    = is_busy(state_q);

   phase_timer #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_phase_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (timer_clear_c),
      .enable   (timer_en_c),
      .expire_c (expire_c)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         conv_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         conv_q  <= conv_d;
         count_q <= count_d;
      end
   end

   // Next-state logic; abort beats everything, a done beats the watchdog.
   always_comb begin
      state_d      = state_q;
      conv_d       = conv_q;
      count_d      = count_q;
      frame_done_d = 1'b0;
      phase_done_c = 1'b0;

      case (state_q)
         S_INIT:    phase_done_c = init_buffer_done;
         S_DEPTH:   phase_done_c = depth_done;
         S_POINT:   phase_done_c = point_done;
         S_POOL:    phase_done_c = pool_done;
         S_FLATTEN: phase_done_c = flatten_done;
         S_FC1:     phase_done_c = fc1_done;
         S_FC2:     phase_done_c = fc2_done;
         default:   phase_done_c = 1'b0;
      endcase

      if (abort) begin
         state_d = S_IDLE;
         conv_d  = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_d = S_INIT;
                  conv_d  = '0;
               end
            end
            S_INIT:    if (phase_done_c) state_d = S_DEPTH;
            S_DEPTH:   if (phase_done_c) state_d = S_POINT;
            S_POINT:   if (phase_done_c) state_d = S_POOL;
            S_POOL: begin
               if (phase_done_c) begin
                  if (conv_q == LAST_IDX) begin
                     state_d = S_FLATTEN;
                  end else begin
                     conv_d  = conv_q + IDX_W'(1);
                     state_d = S_INIT;
                  end
               end
            end
            S_FLATTEN: if (phase_done_c) state_d = S_FC1;
            S_FC1:     if (phase_done_c) state_d = S_FC2;
            S_FC2: begin
               if (phase_done_c) begin
                  frame_done_d = 1'b1;
                  count_d      = count_q + FRAME_W'(1);
                  conv_d       = '0;
                  state_d      = continuous ? S_INIT : S_IDLE;
               end
            end
            S_ERROR:   state_d = S_ERROR;
            default:   state_d = S_ERROR;
         endcase

         if (is_busy(state_q) && !phase_done_c && expire_c) begin
            state_d = S_ERROR;
         end
      end
   end

   // Output decode from the upcoming state; same-cycle descriptor writes bypass.
   always_comb begin
      en_d      = en_of(state_d);
      code_d    = state_code(state_d);
      busy_d    = is_busy(state_d);
      timeout_d = (state_d == S_ERROR);
      size_d    = '0;
      in_ch_d   = '0;
      out_ch_d  = '0;
      if (is_conv(state_d)) begin
         if (cfg_ok_c && (cfg_idx == conv_d)) begin
            size_d   = cfg_in_size;
            in_ch_d  = cfg_in_ch;
            out_ch_d = cfg_out_ch;
         end else begin
            size_d   = d_in_size_q[conv_d];
            in_ch_d  = d_in_ch_q[conv_d];
            out_ch_d = d_out_ch_q[conv_d];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_q         <= EN_OFF;
         code_q       <= '0;
         busy_q       <= 1'b0;
         timeout_q    <= 1'b0;
         frame_done_q <= 1'b0;
         size_q       <= '0;
         in_ch_q      <= '0;
         out_ch_q     <= '0;
      end else begin
         en_q         <= en_d;
         code_q       <= code_d;
         busy_q       <= busy_d;
         timeout_q    <= timeout_d;
         frame_done_q <= frame_done_d;
         size_q       <= size_d;
         in_ch_q      <= in_ch_d;
         out_ch_q     <= out_ch_d;
      end
   end

   assign state          = code_q;
   assign conv_idx       = conv_q;
   assign DSU_en         = en_q.dsu;
   assign init_buffer    = en_q.init_buffer;
   assign depth_en       = en_q.depth;
   assign point_en       = en_q.point;
   assign flatten_en     = en_q.flatten;
   assign fc1            = en_q.fc1;
   assign fc2            = en_q.fc2;
   assign input_size     = size_q;
   assign output_size    = size_q;
   assign input_channel  = in_ch_q;
   assign output_channel = out_ch_q;
   assign busy           = busy_q;
   assign frame_done     = frame_done_q;
   assign timeout_err    = timeout_q;
   assign feature_count  = count_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Self-checking bench for layer_sequencer: directed scenarios plus random
// traffic, checked every cycle against a frame-position reference model.
module tb_layer_sequencer;

   localparam int NC        = 3;
   localparam int DW        = 8;
   localparam int FW        = 2;
   localparam int TO        = 10;
   localparam int FRAME_LEN = 4 * NC + 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start, continuous, abort, cfg_we;
   logic [1:0]    cfg_idx;
   logic [DW-1:0] cfg_in_size, cfg_in_ch, cfg_out_ch;
   logic          init_buffer_done, depth_done, point_done, pool_done;
   logic          flatten_done, fc1_done, fc2_done;
   logic [2:0]    state;
   logic [1:0]    conv_idx;
   logic          DSU_en, init_buffer, depth_en, point_en, flatten_en, fc1, fc2;
   logic [DW-1:0] input_size, output_size, input_channel, output_channel;
   logic          busy, frame_done, timeout_err;
   logic [FW-1:0] feature_count;

   layer_sequencer #(
      .NUM_CONV(NC), .DIM_W(DW), .FRAME_W(FW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
      .abort(abort), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
      .cfg_in_size(cfg_in_size), .cfg_in_ch(cfg_in_ch), .cfg_out_ch(cfg_out_ch),
      .init_buffer_done(init_buffer_done), .depth_done(depth_done),
      .point_done(point_done), .pool_done(pool_done),
      .flatten_done(flatten_done), .fc1_done(fc1_done), .fc2_done(fc2_done),
      .state(state), .conv_idx(conv_idx), .DSU_en(DSU_en),
      .init_buffer(init_buffer), .depth_en(depth_en), .point_en(point_en),
      .flatten_en(flatten_en), .fc1(fc1), .fc2(fc2),
      .input_size(input_size), .output_size(output_size),
      .input_channel(input_channel), .output_channel(output_channel),
      .busy(busy), .frame_done(frame_done), .timeout_err(timeout_err),
      .feature_count(feature_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;
   int seen_fd, busy_cycles;

   // Reference model: mode 0 idle, 1 running, 2 error; position within frame.
   int            m_mode, m_pos, m_cyc;
   logic [FW-1:0] m_count;
   logic          m_fd;
   logic [DW-1:0] m_in [NC];
   logic [DW-1:0] m_ic [NC];
   logic [DW-1:0] m_oc [NC];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int m_phase();
      if (m_pos < 4 * NC) return 1 + (m_pos % 4);
      return 5 + (m_pos - 4 * NC);
   endfunction

   task automatic model_reset();
      m_mode = 0; m_pos = 0; m_cyc = 0; m_count = '0; m_fd = 1'b0;
      for (int i = 0; i < NC; i++) begin
         m_in[i] = '0; m_ic[i] = '0; m_oc[i] = '0;
      end
   endtask

   task automatic model_step();
      bit [7:0] dn;
      m_fd = 1'b0;
      if (m_mode != 1 && cfg_we && int'(cfg_idx) < NC) begin
         m_in[cfg_idx] = cfg_in_size;
         m_ic[cfg_idx] = cfg_in_ch;
         m_oc[cfg_idx] = cfg_out_ch;
      end
      if (abort) begin
         m_mode = 0; m_pos = 0; m_cyc = 0;
      end else if (m_mode == 0) begin
         if (start) begin
            m_mode = 1; m_pos = 0; m_cyc = 0;
         end
      end else if (m_mode == 1) begin
         dn = {fc2_done, fc1_done, flatten_done, pool_done, point_done,
               depth_done, init_buffer_done, 1'b0};
         if (dn[m_phase()]) begin
            m_pos++;
            m_cyc = 0;
            if (m_pos == FRAME_LEN) begin
               m_fd = 1'b1;
               m_count = m_count + 1'b1;
               m_pos = 0;
               if (!continuous) m_mode = 0;
            end
         end else begin
            m_cyc++;
            if (m_cyc == TO) m_mode = 2;
         end
      end
   endtask

   task automatic check_all();
      logic [6:0]    en_e;
      logic [DW-1:0] isz, ich, och;
      logic [2:0]    code;
      int            ph, stg;
      en_e = '0; isz = '0; ich = '0; och = '0; code = 3'd0;
      if (m_mode == 2) begin
         code = 3'd7;
      end else if (m_mode == 1) begin
         ph = m_phase();
         code = 3'(ph);
         case (ph)
            1: en_e = 7'b1111000;
            2: en_e = 7'b1011000;
            3: en_e = 7'b1001000;
            4: en_e = 7'b1000000;
            5: en_e = 7'b0000100;
            6: en_e = 7'b0000010;
            default: en_e = 7'b0000001;
         endcase
         if (ph <= 4) begin
            stg = m_pos / 4;
            isz = m_in[stg]; ich = m_ic[stg]; och = m_oc[stg];
            check("conv_idx", 32'(conv_idx), 32'(stg));
         end
      end
      check("state", 32'(state), 32'(code));
      check("busy", 32'(busy), 32'(m_mode == 1));
      check("timeout_err", 32'(timeout_err), 32'(m_mode == 2));
      check("enables", 32'({DSU_en, init_buffer, depth_en, point_en, flatten_en, fc1, fc2}),
            32'(en_e));
      check("input_size", 32'(input_size), 32'(isz));
      check("output_size", 32'(output_size), 32'(isz));
      check("input_channel", 32'(input_channel), 32'(ich));
      check("output_channel", 32'(output_channel), 32'(och));
      check("frame_done", 32'(frame_done), 32'(m_fd));
      check("feature_count", 32'(feature_count), 32'(m_count));
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      check_all();
      seen_fd     += int'(frame_done);
      busy_cycles += int'(busy);
   endtask

   task automatic set_dones(input logic v);
      init_buffer_done = v; depth_done = v; point_done = v; pool_done = v;
      flatten_done = v; fc1_done = v; fc2_done = v;
   endtask

   task automatic cfg_write(input logic [1:0] idx, input logic [DW-1:0] a,
                            input logic [DW-1:0] b, input logic [DW-1:0] c);
      cfg_we = 1'b1; cfg_idx = idx; cfg_in_size = a; cfg_in_ch = b; cfg_out_ch = c;
      step();
      cfg_we = 1'b0;
   endtask

   initial begin
      logic [DW-1:0] captured;
      int dcyc;

      rst_n = 1'b0; start = 1'b0; continuous = 1'b0; abort = 1'b0; cfg_we = 1'b0;
      cfg_idx = '0; cfg_in_size = '0; cfg_in_ch = '0; cfg_out_ch = '0;
      set_dones(1'b0);
      model_reset();
      seen_fd = 0; busy_cycles = 0;
      #12;
      check_all();
      @(negedge clk);
      rst_n = 1'b1;

      // Program descriptors and run one frame with all dones high.
      cfg_write(2'd0, 8'd32, 8'd3, 8'd32);
      cfg_write(2'd1, 8'd16, 8'd32, 8'd32);
      cfg_write(2'd2, 8'd8, 8'd32, 8'd64);
      set_dones(1'b1);
      seen_fd = 0; busy_cycles = 0;
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (FRAME_LEN + 1) step();
      check("frame1_len", 32'(busy_cycles), 32'(15));
      check("frame1_pulses", 32'(seen_fd), 32'(1));
      check("frame1_count", 32'(feature_count), 32'(1));

      // Four back-to-back frames in continuous mode.
      seen_fd = 0; busy_cycles = 0;
      continuous = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      repeat (4 * FRAME_LEN - 1) step();
      continuous = 1'b0;
      step();
      check("cont_pulses", 32'(seen_fd), 32'(4));
      check("cont_no_gap", 32'(busy_cycles), 32'(4 * FRAME_LEN));
      check("cont_count_wrap", 32'(feature_count), 32'(1));

      // Abort in POINT of stage 1.
      seen_fd = 0;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 20 && !(state == 3'd3 && conv_idx == 2'd1); i++) step();
      check("reach_point_s1", 32'({state, conv_idx}), 32'({3'd3, 2'd1}));
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("abort_idle", 32'(state), 32'(0));
      check("abort_no_pulse", 32'(seen_fd), 32'(0));
      check("abort_count", 32'(feature_count), 32'(1));

      // Start and abort together: abort wins.
      start = 1'b1; abort = 1'b1;
      step();
      start = 1'b0; abort = 1'b0;
      check("start_abort", 32'(busy), 32'(0));

      // Watchdog: withhold depth_done.
      depth_done = 1'b0;
      dcyc = 0;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 40 && timeout_err !== 1'b1; i++) begin
         step();
         if (state == 3'd2 && timeout_err == 1'b0) dcyc++;
      end
      check("wd_depth_cycles", 32'(dcyc), 32'(TO));
      check("wd_err", 32'({timeout_err, busy, state}), 32'({1'b1, 1'b0, 3'd7}));
      repeat (3) step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("wd_abort_idle", 32'({timeout_err, state}), 32'(0));

      // Descriptor writes while busy and with an out-of-range index are dropped.
      set_dones(1'b0);
      start = 1'b1;
      step();
      start = 1'b0;
      cfg_we = 1'b1; cfg_idx = 2'd0; cfg_in_size = 8'hAA; cfg_in_ch = 8'hBB; cfg_out_ch = 8'hCC;
      repeat (3) step();
      cfg_we = 1'b0;
      abort = 1'b1;
      step();
      abort = 1'b0;
      cfg_write(2'd3, 8'h11, 8'h22, 8'h33);
      cfg_write(2'd2, 8'd4, 8'd64, 8'd128);
      set_dones(1'b1);
      captured = '0;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < FRAME_LEN + 1; i++) begin
         step();
         if (state == 3'd1 && conv_idx == 2'd2) captured = input_size;
         if (state == 3'd1 && conv_idx == 2'd0) check("busy_write_dropped", 32'(input_size), 32'(32));
      end
      check("new_desc_used", 32'(captured), 32'(4));

      // Random traffic.
      for (int i = 0; i < 500; i++) begin
         start            = ($urandom % 4) == 0;
         abort            = ($urandom % 40) == 0;
         continuous       = 1'($urandom);
         init_buffer_done = ($urandom % 4) != 0;
         depth_done       = ($urandom % 4) != 0;
         point_done       = ($urandom % 4) != 0;
         pool_done        = ($urandom % 4) != 0;
         flatten_done     = ($urandom % 4) != 0;
         fc1_done         = ($urandom % 4) != 0;
         fc2_done         = ($urandom % 4) != 0;
         cfg_we           = ($urandom % 8) == 0;
         cfg_idx          = 2'($urandom);
         cfg_in_size      = 8'($urandom);
         cfg_in_ch        = 8'($urandom);
         cfg_out_ch       = 8'($urandom);
         step();
      end
      start = 1'b0; continuous = 1'b0; cfg_we = 1'b0;
      abort = 1'b1;
      step();
      abort = 1'b0;

      // Asynchronous reset in the middle of FC1.
      set_dones(1'b1);
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 30 && state != 3'd6; i++) step();
      check("reach_fc1", 32'(state), 32'(6));
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      @(negedge clk);
      rst_n = 1'b1;

      // Descriptors are back to zero after reset.
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (FRAME_LEN + 1) step();
      check("post_reset_count", 32'(feature_count), 32'(1));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
